// File: rtl/yacc_pkg.sv
// Shared types and helpers for the YACC cache access arbiter.
// Counters up to 64 bits wide are supported by sat_inc.
package yacc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } yacc_state_e;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_CNT_W  = 32;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/yacc_rr_select.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr_i.
module yacc_rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    // Scan from the farthest slot back to rr_ptr_i so the nearest hit wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx         = '0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yacc_access_arbiter.sv
// Round-robin sequencer sharing the YACC cache address port among NUM_REQ
// requesters, returning hit/miss to the owner and keeping saturating statistics.
module yacc_access_arbiter
    import yacc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_hit,
    output logic                      cache_valid,
    output logic [ADDR_W-1:0]         cache_addr,
    input  logic                      cache_ready,
    input  logic                      cache_done,
    input  logic                      cache_hit,
    output logic                      busy,
    output logic [CNT_W-1:0]          access_count,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    yacc_state_e          state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     owner_q;
    logic                 cache_valid_q;
    logic [ADDR_W-1:0]    cache_addr_q;
    logic [NUM_REQ-1:0]   resp_valid_q;
    logic                 resp_hit_q;
    logic [CNT_W-1:0]     access_q;
    logic [CNT_W-1:0]     hit_q;
    logic [CNT_W-1:0]     miss_q;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [ADDR_W-1:0]    sel_addr;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic [CNT_W-1:0]     access_d;
    logic [CNT_W-1:0]     hit_d;
    logic [CNT_W-1:0]     miss_d;

    yacc_rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    assign sel_addr = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
    assign rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    assign access_d = CNT_W'(sat_inc(64'(access_q), CNT_W));
    assign hit_d    = CNT_W'(sat_inc(64'(hit_q), CNT_W));
    assign miss_d   = CNT_W'(sat_inc(64'(miss_q), CNT_W));

    // Handshakes arriving outside their consuming state fall through the case untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            resp_valid_q  <= '0;
            resp_hit_q    <= 1'b0;
            access_q      <= '0;
            hit_q         <= '0;
            miss_q        <= '0;
        end else begin
            resp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        cache_addr_q  <= sel_addr;
                        owner_q       <= grant_idx;
                        cache_valid_q <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache_ready) begin
                        cache_valid_q <= 1'b0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cache_done) begin
                        resp_valid_q <= NUM_REQ'(1) << owner_q;
                        resp_hit_q   <= cache_hit;
                        access_q     <= access_d;
                        if (cache_hit) begin
                            hit_q <= hit_d;
                        end else begin
                            miss_q <= miss_d;
                        end
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    cache_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE) ? grant : '0;
    assign busy         = (state_q != IDLE);
    assign cache_valid  = cache_valid_q;
    assign cache_addr   = cache_addr_q;
    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_hit_q;
    assign access_count = access_q;
    assign hit_count    = hit_q;
    assign miss_count   = miss_q;

endmodule
